// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding, reset
// defaults, FSM state encoding and PC arithmetic helper.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR_DEF    = 32'hFC00_0000;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] ADDR_STEP_DEF    = 32'd1;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // PC advance, deliberately modulo 2^32 with no overflow indication
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] step);
        return addr + step;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: strobe + address out, data back one cycle later.
interface instr_fetch_unit_if;

    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_hold_buf.sv
// Captures the in-flight word when IF/ID stalls and selects what is presented
// to IF/ID: live memory data, the held word, or a NOP bubble.
module instr_fetch_unit_hold_buf
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [31:0] ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         squash,
    input  fetch_state_t state,
    input  logic [31:0]  rd_data,
    input  logic [31:0]  issued_addr,
    output logic [31:0]  instruction_out,
    output logic [31:0]  pc_out,
    output logic         fetch_valid
);

    logic [31:0] hold_instr_r;
    logic [31:0] hold_pc_r;

    // Hold registers: latch the word returning from memory on the first stall cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_instr_r <= 32'h0000_0000;
            hold_pc_r    <= 32'h0000_0000;
        end else if (capture) begin
            hold_instr_r <= rd_data;
            hold_pc_r    <= issued_addr;
        end else begin
            hold_instr_r <= hold_instr_r;
            hold_pc_r    <= hold_pc_r;
        end
    end

    // Output select; a redirect squashes whatever would otherwise be shown
    always_comb begin
        instruction_out = NOP_INSTR;
        pc_out          = 32'h0000_0000;
        fetch_valid     = 1'b0;
        if (squash) begin
            instruction_out = NOP_INSTR;
            pc_out          = 32'h0000_0000;
            fetch_valid     = 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    instruction_out = rd_data;
                    pc_out          = next_addr(issued_addr, ADDR_STEP);
                    fetch_valid     = 1'b1;
                end
                ST_HOLD: begin
                    instruction_out = hold_instr_r;
                    pc_out          = next_addr(hold_pc_r, ADDR_STEP);
                    fetch_valid     = 1'b1;
                end
                default: begin
                    instruction_out = NOP_INSTR;
                    pc_out          = 32'h0000_0000;
                    fetch_valid     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to 1-cycle synchronous imem,
// and feeds {instruction, PC} to IF/ID with zero-bubble stall restart.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] ADDR_STEP    = ADDR_STEP_DEF,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_hazard,
    input  logic                       PC_hazard,
    input  logic                       pop_haz,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                instruction_out,
    output logic [31:0]                PC_out,
    output logic                       fetch_valid
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  issued_addr_r;
    logic         stall_s;
    logic         capture_s;
    logic         rd_en_s;
    logic [31:0]  addr_s;

    // Stall merge, read strobe and address; a redirect issues its target immediately
    always_comb begin
        stall_s   = data_hazard | PC_hazard | pop_haz;
        rd_en_s   = 1'b0;
        addr_s    = pc_r;
        capture_s = 1'b0;
        if (rst) begin
            rd_en_s = 1'b0;
        end else if (redirect_valid) begin
            rd_en_s = 1'b1;
            addr_s  = redirect_pc;
        end else begin
            rd_en_s   = !stall_s;
            capture_s = (state_r == ST_RUN) && stall_s;
        end
    end

    assign imem.imem_rd_en = rd_en_s;
    assign imem.imem_addr  = addr_s;

    // Fetch FSM and PC bookkeeping; redirect outranks every stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_VECTOR;
            issued_addr_r <= 32'h0000_0000;
        end else if (redirect_valid) begin
            state_r       <= ST_RUN;
            issued_addr_r <= redirect_pc;
            pc_r          <= next_addr(redirect_pc, ADDR_STEP);
        end else begin
            case (state_r)
                ST_BOOT, ST_HOLD: begin
                    if (!stall_s) begin
                        state_r       <= ST_RUN;
                        issued_addr_r <= pc_r;
                        pc_r          <= next_addr(pc_r, ADDR_STEP);
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (!stall_s) begin
                        issued_addr_r <= pc_r;
                        pc_r          <= next_addr(pc_r, ADDR_STEP);
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r       <= ST_BOOT;
                    pc_r          <= RESET_VECTOR;
                    issued_addr_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    instr_fetch_unit_hold_buf #(
        .NOP_INSTR (NOP_INSTR),
        .ADDR_STEP (ADDR_STEP)
    ) u_hold_buf (
        .clk             (clk),
        .rst             (rst),
        .capture         (capture_s),
        .squash          (redirect_valid),
        .state           (state_r),
        .rd_data         (imem.imem_rdata),
        .issued_addr     (issued_addr_r),
        .instruction_out (instruction_out),
        .pc_out          (PC_out),
        .fetch_valid     (fetch_valid)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle synchronous imem model
// whose word at address a is 32'h1000_0000 + a.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic        clk;
    logic        rst;
    logic        data_hazard;
    logic        PC_hazard;
    logic        pop_haz;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;
    logic        fetch_valid;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .data_hazard     (data_hazard),
        .PC_hazard       (PC_hazard),
        .pop_haz         (pop_haz),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem            (imem_bus.master),
        .instruction_out (instruction_out),
        .PC_out          (PC_out),
        .fetch_valid     (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory
    always @(posedge clk) begin
        if (imem_bus.imem_rd_en) imem_bus.imem_rdata <= 32'h1000_0000 + imem_bus.imem_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data_hazard = 1'b0; PC_hazard = 1'b0; pop_haz = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        tick(); tick();
        @(negedge clk);
        chk32("reset_instr", instruction_out, NOP);
        chk32("reset_pc", PC_out, 32'h0000_0000);
        chk1("reset_valid", fetch_valid, 1'b0);
        chk1("reset_rd_en", imem_bus.imem_rd_en, 1'b0);
    endtask

    task automatic test_sequential();
        tick(); rst = 1'b0;
        @(negedge clk);
        chk1("boot_rd_en", imem_bus.imem_rd_en, 1'b1);
        chk32("boot_addr", imem_bus.imem_addr, 32'h0000_0000);
        chk1("boot_valid", fetch_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk32("seq_instr", instruction_out, 32'h1000_0000 + i);
            chk32("seq_pc", PC_out, i + 1);
            chk1("seq_valid", fetch_valid, 1'b1);
            chk32("seq_addr", imem_bus.imem_addr, i + 1);
        end
    endtask

    task automatic test_data_hazard();
        for (int k = 0; k < 3; k++) begin
            tick(); data_hazard = 1'b1;
            @(negedge clk);
            chk32("haz_instr", instruction_out, 32'h1000_0004);
            chk32("haz_pc", PC_out, 32'h0000_0005);
            chk1("haz_rd_en", imem_bus.imem_rd_en, 1'b0);
            chk1("haz_valid", fetch_valid, 1'b1);
        end
        tick(); data_hazard = 1'b0;
        @(negedge clk);
        chk32("rel_instr", instruction_out, 32'h1000_0004);
        chk1("rel_rd_en", imem_bus.imem_rd_en, 1'b1);
        chk32("rel_addr", imem_bus.imem_addr, 32'h0000_0005);
        tick();
        @(negedge clk);
        chk32("after_rel_instr", instruction_out, 32'h1000_0005);
        chk32("after_rel_pc", PC_out, 32'h0000_0006);
    endtask

    task automatic test_redirect();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        chk32("redir_instr", instruction_out, NOP);
        chk1("redir_valid", fetch_valid, 1'b0);
        chk32("redir_pc", PC_out, 32'h0000_0000);
        chk32("redir_addr", imem_bus.imem_addr, 32'h0000_0040);
        chk1("redir_rd_en", imem_bus.imem_rd_en, 1'b1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk32("tgt_instr", instruction_out, 32'h1000_0040);
        chk32("tgt_pc", PC_out, 32'h0000_0041);
        chk32("tgt_addr", imem_bus.imem_addr, 32'h0000_0041);
    endtask

    task automatic test_redirect_in_hold();
        int nops = 0;
        tick(); pop_haz = 1'b1;
        @(negedge clk);
        chk32("pre_hold_instr", instruction_out, 32'h1000_0041);
        tick();
        @(negedge clk);
        chk32("hold_instr", instruction_out, 32'h1000_0041);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        @(negedge clk);
        if (instruction_out === NOP) nops++;
        chk1("hredir_valid", fetch_valid, 1'b0);
        chk32("hredir_addr", imem_bus.imem_addr, 32'h0000_0080);
        chk1("hredir_rd_en", imem_bus.imem_rd_en, 1'b1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        if (instruction_out === NOP) nops++;
        chk32("hstall1_instr", instruction_out, 32'h1000_0080);
        chk32("hstall1_pc", PC_out, 32'h0000_0081);
        chk1("hstall1_rd_en", imem_bus.imem_rd_en, 1'b0);
        tick();
        @(negedge clk);
        if (instruction_out === NOP) nops++;
        chk32("hstall2_instr", instruction_out, 32'h1000_0080);
        tick(); pop_haz = 1'b0;
        @(negedge clk);
        if (instruction_out === NOP) nops++;
        chk32("hrel_instr", instruction_out, 32'h1000_0080);
        chk32("hrel_addr", imem_bus.imem_addr, 32'h0000_0081);
        tick();
        @(negedge clk);
        if (instruction_out === NOP) nops++;
        chk32("hnext_instr", instruction_out, 32'h1000_0081);
        chk32("nop_count", nops, 32'd1);
    endtask

    task automatic test_wrap();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        chk32("wrap_issue_addr", imem_bus.imem_addr, 32'hFFFF_FFFF);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk32("wrap_instr", instruction_out, 32'h0FFF_FFFF);
        chk32("wrap_pc", PC_out, 32'h0000_0000);
        chk32("wrap_addr", imem_bus.imem_addr, 32'h0000_0000);
        tick();
        @(negedge clk);
        chk32("wrap_next_instr", instruction_out, 32'h1000_0000);
        chk32("wrap_next_pc", PC_out, 32'h0000_0001);
    endtask

    task automatic test_async_reset();
        tick(); data_hazard = 1'b1;
        tick();
        @(negedge clk);
        chk1("pre_rst_valid", fetch_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk32("arst_instr", instruction_out, NOP);
        chk32("arst_pc", PC_out, 32'h0000_0000);
        chk1("arst_valid", fetch_valid, 1'b0);
        chk1("arst_rd_en", imem_bus.imem_rd_en, 1'b0);
        tick(); data_hazard = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_rd_en", imem_bus.imem_rd_en, 1'b1);
        chk32("post_rst_addr", imem_bus.imem_addr, 32'h0000_0000);
        tick();
        @(negedge clk);
        chk32("post_rst_instr", instruction_out, 32'h1000_0000);
        chk32("post_rst_pc", PC_out, 32'h0000_0001);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_data_hazard();
        test_redirect();
        test_redirect_in_hold();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
